multicycle_main_controller: RTL and testbench
=============================================

Name: multicycle_main_controller

Overview:
Main control FSM for the multicycle RV32I-subset core, directly upstream of the ALU controller. It decodes the instruction register's opcode, sequences fetch, decode, execute, memory and writeback steps, and drives all datapath enables and muxes. It produces the 2-bit ALUOp that the ALU controller consumes together with funct3/funct7. The ALUOp encoding is fixed: 00 = add, 01 = branch compare, 10 = R-type, 11 = I-type ALU.

Parameters:
ILLEGAL_HALT, 0, 1 = stay in ILLEGAL forever once entered; 0 = return to FETCH after one cycle.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  7  instr[6:0] from the instruction register (valid from DECODE onward)
zero  input  1  ALU branch-condition flag; 1 = condition true
mem_ready  input  1  memory handshake; access completes in the cycle it is high
mem_req  output  1  memory access request
adr_src  output  1  0 = PC, 1 = ALUOut as memory address
mem_write  output  1  memory write strobe
ir_write  output  1  load IR and OldPC
pc_write  output  1  PC load enable
reg_write  output  1  register file write enable
result_src  output  2  00 ALUOut, 01 read-data reg, 10 ALUResult, 11 ImmExt
alu_src_a  output  2  00 PC, 01 OldPC, 10 rs1 reg
alu_src_b  output  2  00 rs2 reg, 01 ImmExt, 10 constant 4
imm_src  output  3  000 I, 001 S, 010 B, 011 J, 100 U
alu_op  output  2  to ALU controller
illegal  output  1  sticky unsupported-opcode flag
state_dbg  output  4  current state code

Behaviour:
- Async reset (rst_n low): state = FETCH (code 0) and illegal = 0. While reset is asserted, mem_write, ir_write, pc_write and reg_write are forced to 0.
- Outputs are Moore outputs decoded from the state register, except for the mem_ready and zero gating noted below.
- imm_src is decoded combinationally from opcode in every state:
  - lw/jalr/OP-IMM → I
  - sw → S
  - branch → B
  - jal → J
  - lui → U
  - others → 000
- pc_write = pc_update | (branch & zero). pc_update and branch are internal state decodes.
- Default for every output not listed in a state: 0.
- States, per-state outputs and next state:
  - FETCH(0): mem_req=1, adr_src=0, A=00, B=10, alu_op=00, result_src=10. ir_write = pc_update = mem_ready. Stays in FETCH until mem_ready, then → DECODE.
  - DECODE(1): A=01, B=01, alu_op=00 (precomputes OldPC+imm into ALUOut). Next state by opcode:
    - 0000011 → MEMADR
    - 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 1100111 → JALR
    - 0110111 → LUI
    - anything else → ILLEGAL
  - MEMADR(2): A=10, B=01, alu_op=00. → MEMREAD if opcode is lw, else MEMWRITE.
  - MEMREAD(3): mem_req=1, adr_src=1, result_src=00. Holds until mem_ready, then → MEMWB.
  - MEMWB(4): result_src=01, reg_write=1. → FETCH.
  - MEMWRITE(5): mem_req=1, adr_src=1, mem_write=1, result_src=00. mem_write and the address stay stable until mem_ready, then → FETCH.
  - EXECR(6): A=10, B=00, alu_op=10. → ALUWB.
  - EXECI(7): A=10, B=01, alu_op=11. → ALUWB.
  - ALUWB(8): result_src=00, reg_write=1. → FETCH.
  - BRANCH(9): A=10, B=00, alu_op=01, result_src=00, branch=1. PC loads ALUOut only if zero=1. → FETCH.
  - JAL(10): A=01, B=10, alu_op=00, result_src=00, pc_update=1 (PC ← target; ALUOut ← OldPC+4). → ALUWB.
  - JALR(11): A=10, B=01, alu_op=00 (ALUOut ← rs1+imm). → JAL.
  - LUI(12): result_src=11, reg_write=1. → FETCH.
  - ILLEGAL(13): no enables asserted. illegal is set to 1 and stays 1 until reset. → FETCH, or stays in ILLEGAL if ILLEGAL_HALT=1.
- Cycle counts with mem_ready always high:
  - R-type, I-type ALU, jal: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - branch: 3 cycles
  - jalr: 5 cycles
  - lui: 3 cycles
- Each cycle that mem_ready is low in a wait state adds one cycle.
- Reset mid-instruction: the FSM returns to FETCH immediately with no pending write completed. mem_write and the other write enables are 0 in the same cycle, combinationally.
- Unused state codes 14–15 → FETCH on the next clock, with no enables asserted.

Test Plan:
1. Reset, then add x3,x1,x2 (opcode 0110011) with mem_ready=1 → states 0,1,6,8,0. alu_op=10 in EXECR; reg_write=1 only in ALUWB; ir_write and pc_write high in FETCH only.
2. lw (0000011) with mem_ready low for 2 cycles in MEMREAD → stays in state 3 for 3 cycles with mem_req=1 and adr_src=1. Then state 4 with result_src=01 and reg_write=1. Total 7 cycles.
3. beq (1100011) with zero=1 → in BRANCH: alu_op=01, pc_write=1. Repeat with zero=0 → pc_write=0. Both cases return to FETCH after 3 cycles.
4. jalr (1100111) → sequence 0,1,11,10,8. pc_write=1 only in FETCH and JAL; imm_src=000; reg_write=1 in ALUWB.
5. Opcode 1111111 → DECODE then ILLEGAL (13). illegal=1 and stays 1 after the FSM returns to FETCH. With ILLEGAL_HALT=1, state_dbg stays at 13.
6. sw (0100011) with rst_n pulled low while in MEMWRITE and mem_ready=0 → mem_write drops to 0 immediately and state_dbg=0. After release, the FSM restarts FETCH normally.

Source files
------------

// File: rtl/multicycle_main_controller.sv
// multicycle_main_controller
// Main control FSM for the multicycle RV32I-subset core. It decodes the
// instruction register's opcode, sequences the fetch, decode, execute, memory
// and writeback steps, and drives the datapath enables, muxes and the ALUOp
// code consumed by the ALU controller.
//
// Parameters:
//   ILLEGAL_HALT  1 = park in ILLEGAL forever, 0 = return to FETCH after one cycle
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   opcode[6:0] in   instr[6:0] from the instruction register
//   zero        in   ALU branch-condition flag (1 = condition true)
//   mem_ready   in   memory handshake, access completes while high
//   mem_req     out  memory access request
//   adr_src     out  memory address select (0 PC, 1 ALUOut)
//   mem_write   out  memory write strobe
//   ir_write    out  load IR and OldPC
//   pc_write    out  PC load enable
//   reg_write   out  register file write enable
//   result_src  out  result mux (00 ALUOut, 01 read data, 10 ALUResult, 11 ImmExt)
//   alu_src_a   out  ALU A mux (00 PC, 01 OldPC, 10 rs1)
//   alu_src_b   out  ALU B mux (00 rs2, 01 ImmExt, 10 constant 4)
//   imm_src     out  immediate format (000 I, 001 S, 010 B, 011 J, 100 U)
//   alu_op      out  00 add, 01 branch compare, 10 R-type, 11 I-type ALU
//   illegal     out  sticky unsupported-opcode flag
//   state_dbg   out  current state code
module multicycle_main_controller #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [1:0] alu_op,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_t;

  state_t state;

  logic pc_update;
  logic branch;
  logic ir_write_raw;
  logic mem_write_raw;
  logic reg_write_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_RTYPE:          state <= S_EXECR;
            OP_IMM:            state <= S_EXECI;
            OP_BRANCH:         state <= S_BRANCH;
            OP_JAL:            state <= S_JAL;
            OP_JALR:           state <= S_JALR;
            OP_LUI:            state <= S_LUI;
            default: begin
              // Flag is raised on entry so it is visible while in ILLEGAL.
              state   <= S_ILLEGAL;
              illegal <= 1'b1;
            end
          endcase
        end
        S_MEMADR:   state <= (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (mem_ready) state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_JAL:      state <= S_ALUWB;
        // JALR reuses JAL: ALUOut already holds rs1+imm, which JAL loads into PC.
        S_JALR:     state <= S_JAL;
        S_LUI:      state <= S_FETCH;
        S_ILLEGAL:  state <= ILLEGAL_HALT ? S_ILLEGAL : S_FETCH;
        default:    state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    mem_req       = 1'b0;
    adr_src       = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    case (state)
      S_FETCH: begin
        mem_req      = 1'b1;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        ir_write_raw = mem_ready;
        pc_update    = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req       = 1'b1;
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
      end
      S_ALUWB:  reg_write_raw = 1'b1;
      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      S_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_LUI: begin
        result_src    = 2'b11;
        reg_write_raw = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_LOAD, OP_JALR, OP_IMM: imm_src = 3'b000;
      OP_STORE:                 imm_src = 3'b001;
      OP_BRANCH:                imm_src = 3'b010;
      OP_JAL:                   imm_src = 3'b011;
      OP_LUI:                   imm_src = 3'b100;
      default:                  imm_src = 3'b000;
    endcase
  end

  // Write enables are gated by rst_n so they drop in the same cycle reset
  // asserts, even though FETCH would otherwise follow mem_ready.
  assign mem_write = rst_n & mem_write_raw;
  assign ir_write  = rst_n & ir_write_raw;
  assign reg_write = rst_n & reg_write_raw;
  assign pc_write  = rst_n & (pc_update | (branch & zero));
  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_main_controller.sv
module tb_multicycle_main_controller;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       mem_req, adr_src, mem_write, ir_write, pc_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_src;
  logic [3:0] state_dbg;

  logic       h_mem_req, h_adr_src, h_mem_write, h_ir_write, h_pc_write, h_reg_write, h_illegal;
  logic [1:0] h_result_src, h_alu_src_a, h_alu_src_b, h_alu_op;
  logic [2:0] h_imm_src;
  logic [3:0] h_state_dbg;

  int n_cmp  = 0;
  int n_fail = 0;

  multicycle_main_controller #(.ILLEGAL_HALT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_op(alu_op),
    .illegal(illegal), .state_dbg(state_dbg)
  );

  multicycle_main_controller #(.ILLEGAL_HALT(1'b1)) dut_halt (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(h_mem_req), .adr_src(h_adr_src), .mem_write(h_mem_write), .ir_write(h_ir_write),
    .pc_write(h_pc_write), .reg_write(h_reg_write), .result_src(h_result_src),
    .alu_src_a(h_alu_src_a), .alu_src_b(h_alu_src_b), .imm_src(h_imm_src), .alu_op(h_alu_op),
    .illegal(h_illegal), .state_dbg(h_state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reset asserted with mem_ready high: FETCH would otherwise drive ir_write/pc_write.
  task automatic test_reset();
    rst_n = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = 7'b0110011;
    #2 rst_n = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (state_dbg !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_state: got %0d expected 0", state_dbg); end
    n_cmp++; if (illegal !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_illegal: got %b expected 0", illegal); end
    n_cmp++; if ({ir_write, pc_write, reg_write, mem_write} !== 4'b0000) begin
      n_fail++; $display("[TB] FAIL reset_writes: got %b expected 0000", {ir_write, pc_write, reg_write, mem_write}); end
    rst_n = 1'b1; mem_ready = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (state_dbg !== 4'd0) begin n_fail++; $display("[TB] FAIL fetch_wait_state: got %0d expected 0", state_dbg); end
    n_cmp++; if (ir_write !== 1'b0) begin n_fail++; $display("[TB] FAIL fetch_wait_ir_write: got %b expected 0", ir_write); end
  endtask

  task automatic test_rtype();
    int st [5]; logic [1:0] aop [5]; logic rw [5]; logic iw [5];
    st = '{0, 1, 6, 8, 0}; aop = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    rw = '{0, 0, 0, 1, 0}; iw = '{1, 0, 0, 0, 1};
    opcode = 7'b0110011; mem_ready = 1'b1; zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (state_dbg !== 4'(st[i])) begin n_fail++; $display("[TB] FAIL rtype_state[%0d]: got %0d expected %0d", i, state_dbg, st[i]); end
      n_cmp++; if (alu_op !== aop[i]) begin n_fail++; $display("[TB] FAIL rtype_alu_op[%0d]: got %b expected %b", i, alu_op, aop[i]); end
      n_cmp++; if (reg_write !== rw[i]) begin n_fail++; $display("[TB] FAIL rtype_reg_write[%0d]: got %b expected %b", i, reg_write, rw[i]); end
      n_cmp++; if (ir_write !== iw[i]) begin n_fail++; $display("[TB] FAIL rtype_ir_write[%0d]: got %b expected %b", i, ir_write, iw[i]); end
      n_cmp++; if (pc_write !== iw[i]) begin n_fail++; $display("[TB] FAIL rtype_pc_write[%0d]: got %b expected %b", i, pc_write, iw[i]); end
      if (i < 4) @(negedge clk);
    end
  endtask

  task automatic test_lw_wait();
    int st [8]; logic mr [8];
    st = '{0, 1, 2, 3, 3, 3, 4, 0}; mr = '{1, 1, 1, 0, 0, 1, 1, 1};
    opcode = 7'b0000011; zero = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr[i];
      #1;
      n_cmp++; if (state_dbg !== 4'(st[i])) begin n_fail++; $display("[TB] FAIL lw_state[%0d]: got %0d expected %0d", i, state_dbg, st[i]); end
      n_cmp++; if (reg_write !== (st[i] == 4)) begin n_fail++; $display("[TB] FAIL lw_reg_write[%0d]: got %b expected %b", i, reg_write, st[i] == 4); end
      if (st[i] == 3) begin
        n_cmp++; if ({mem_req, adr_src} !== 2'b11) begin n_fail++; $display("[TB] FAIL lw_memread_req_adr[%0d]: got %b expected 11", i, {mem_req, adr_src}); end
      end
      if (st[i] == 4) begin
        n_cmp++; if (result_src !== 2'b01) begin n_fail++; $display("[TB] FAIL lw_memwb_result_src: got %b expected 01", result_src); end
      end
      if (i < 7) @(negedge clk);
    end
  endtask

  task automatic test_branch();
    int st [4]; logic pw [4];
    st = '{0, 1, 9, 0};
    opcode = 7'b1100011; mem_ready = 1'b1;
    for (int run = 0; run < 2; run++) begin
      zero = (run == 0);
      pw = '{1, 0, (run == 0), 1};
      for (int i = 0; i < 4; i++) begin
        #1;
        n_cmp++; if (state_dbg !== 4'(st[i])) begin n_fail++; $display("[TB] FAIL br%0d_state[%0d]: got %0d expected %0d", run, i, state_dbg, st[i]); end
        n_cmp++; if (pc_write !== pw[i]) begin n_fail++; $display("[TB] FAIL br%0d_pc_write[%0d]: got %b expected %b", run, i, pc_write, pw[i]); end
        if (st[i] == 9) begin
          n_cmp++; if (alu_op !== 2'b01) begin n_fail++; $display("[TB] FAIL br%0d_alu_op: got %b expected 01", run, alu_op); end
          n_cmp++; if (imm_src !== 3'b010) begin n_fail++; $display("[TB] FAIL br%0d_imm_src: got %b expected 010", run, imm_src); end
        end
        if (i < 3) @(negedge clk);
      end
    end
  endtask

  task automatic test_jalr();
    int st [6]; logic pw [6]; logic rw [6];
    st = '{0, 1, 11, 10, 8, 0}; pw = '{1, 0, 0, 1, 0, 1}; rw = '{0, 0, 0, 0, 1, 0};
    opcode = 7'b1100111; mem_ready = 1'b1; zero = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++; if (state_dbg !== 4'(st[i])) begin n_fail++; $display("[TB] FAIL jalr_state[%0d]: got %0d expected %0d", i, state_dbg, st[i]); end
      n_cmp++; if (pc_write !== pw[i]) begin n_fail++; $display("[TB] FAIL jalr_pc_write[%0d]: got %b expected %b", i, pc_write, pw[i]); end
      n_cmp++; if (reg_write !== rw[i]) begin n_fail++; $display("[TB] FAIL jalr_reg_write[%0d]: got %b expected %b", i, reg_write, rw[i]); end
      n_cmp++; if (imm_src !== 3'b000) begin n_fail++; $display("[TB] FAIL jalr_imm_src[%0d]: got %b expected 000", i, imm_src); end
      if (i < 5) @(negedge clk);
    end
  endtask

  task automatic test_sw_reset();
    int st [4]; logic mr [4];
    st = '{0, 1, 2, 5}; mr = '{1, 1, 1, 0};
    opcode = 7'b0100011; zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = mr[i];
      #1;
      n_cmp++; if (state_dbg !== 4'(st[i])) begin n_fail++; $display("[TB] FAIL sw_state[%0d]: got %0d expected %0d", i, state_dbg, st[i]); end
      if (i < 3) @(negedge clk);
    end
    n_cmp++; if ({mem_req, adr_src, mem_write} !== 3'b111) begin n_fail++; $display("[TB] FAIL sw_memwrite_outputs: got %b expected 111", {mem_req, adr_src, mem_write}); end
    rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    n_cmp++; if (mem_write !== 1'b0) begin n_fail++; $display("[TB] FAIL sw_reset_mem_write: got %b expected 0", mem_write); end
    n_cmp++; if (state_dbg !== 4'd0) begin n_fail++; $display("[TB] FAIL sw_reset_state: got %0d expected 0", state_dbg); end
    n_cmp++; if ({ir_write, pc_write, reg_write} !== 3'b000) begin n_fail++; $display("[TB] FAIL sw_reset_writes: got %b expected 000", {ir_write, pc_write, reg_write}); end
    rst_n = 1'b1; mem_ready = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (state_dbg !== 4'd0) begin n_fail++; $display("[TB] FAIL restart_state: got %0d expected 0", state_dbg); end
    mem_ready = 1'b1; opcode = 7'b0110111;
    #1;
    n_cmp++; if ({ir_write, pc_write} !== 2'b11) begin n_fail++; $display("[TB] FAIL restart_fetch_writes: got %b expected 11", {ir_write, pc_write}); end
    n_cmp++; if (imm_src !== 3'b100) begin n_fail++; $display("[TB] FAIL lui_imm_src: got %b expected 100", imm_src); end
    @(negedge clk); #1;
    n_cmp++; if (state_dbg !== 4'd1) begin n_fail++; $display("[TB] FAIL restart_decode: got %0d expected 1", state_dbg); end
    @(negedge clk); #1;
    n_cmp++; if (state_dbg !== 4'd12) begin n_fail++; $display("[TB] FAIL lui_state: got %0d expected 12", state_dbg); end
    n_cmp++; if ({result_src, reg_write} !== 3'b111) begin n_fail++; $display("[TB] FAIL lui_outputs: got %b expected 111", {result_src, reg_write}); end
    @(negedge clk); #1;
    n_cmp++; if (state_dbg !== 4'd0) begin n_fail++; $display("[TB] FAIL lui_return: got %0d expected 0", state_dbg); end
  endtask

  task automatic test_illegal();
    int st [6]; int hst [6]; logic il [6];
    st  = '{0, 1, 13, 0, 1, 6};
    hst = '{0, 1, 13, 13, 13, 13};
    il  = '{0, 0, 1, 1, 1, 1};
    opcode = 7'b1111111; mem_ready = 1'b1; zero = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) opcode = 7'b0110011;
      #1;
      n_cmp++; if (state_dbg !== 4'(st[i])) begin n_fail++; $display("[TB] FAIL ill_state[%0d]: got %0d expected %0d", i, state_dbg, st[i]); end
      n_cmp++; if (h_state_dbg !== 4'(hst[i])) begin n_fail++; $display("[TB] FAIL ill_halt_state[%0d]: got %0d expected %0d", i, h_state_dbg, hst[i]); end
      n_cmp++; if (illegal !== il[i]) begin n_fail++; $display("[TB] FAIL ill_flag[%0d]: got %b expected %b", i, illegal, il[i]); end
      n_cmp++; if (h_illegal !== il[i]) begin n_fail++; $display("[TB] FAIL ill_halt_flag[%0d]: got %b expected %b", i, h_illegal, il[i]); end
      if (st[i] == 13) begin
        n_cmp++; if ({mem_req, ir_write, pc_write, reg_write, mem_write} !== 5'b0) begin
          n_fail++; $display("[TB] FAIL ill_enables: got %b expected 00000", {mem_req, ir_write, pc_write, reg_write, mem_write}); end
      end
      if (i < 5) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({illegal, h_illegal} !== 2'b00) begin n_fail++; $display("[TB] FAIL ill_reset_clear: got %b expected 00", {illegal, h_illegal}); end
    n_cmp++; if (h_state_dbg !== 4'd0) begin n_fail++; $display("[TB] FAIL ill_halt_reset_state: got %0d expected 0", h_state_dbg); end
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting multicycle_main_controller bench");
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch();
    test_jalr();
    test_sw_reset();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
